// File: rtl/pipeline_controller_pkg.sv
// Shared definitions for the pipeline hazard / memory-wait controller.
//   mem_ctrl_state_t   : memory controller FSM states
//   RESULT_SRC_MEM     : result-source encoding that marks a load in Execute
//   MEM_TIMEOUT_CYCLES : memory wait cycles before an access is abandoned
//   sat_inc32          : saturating 32-bit increment used by the stall counter
package pipeline_controller_pkg;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    MEM_WAIT = 1'b1
  } mem_ctrl_state_t;

  localparam logic [1:0] RESULT_SRC_MEM     = 2'b01;
  localparam int         MEM_TIMEOUT_CYCLES = 256;
  localparam int         WAIT_CNT_W         = $clog2(MEM_TIMEOUT_CYCLES);

  // Last wait-counter value before the access is given up on.
  localparam logic [WAIT_CNT_W-1:0] WAIT_CNT_LAST = WAIT_CNT_W'(MEM_TIMEOUT_CYCLES - 1);
  localparam logic [WAIT_CNT_W-1:0] WAIT_CNT_ONE  = WAIT_CNT_W'(1);
  localparam logic [WAIT_CNT_W-1:0] WAIT_CNT_ZERO = WAIT_CNT_W'(0);

  function automatic logic [31:0] sat_inc32(input logic [31:0] value);
    logic [31:0] result;
    if (value == 32'hFFFF_FFFF) begin
      result = value;
    end else begin
      result = value + 32'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/pipeline_controller_hazard_detector.sv
// hazard_detector: combinational load-use and taken-branch detection.
// Ports:
//   RS1_D, RS2_D      in  source registers of the instruction in Decode
//   RD_E              in  destination register of the instruction in Execute
//   Result_Src_Sel_E  in  result source in Execute (RESULT_SRC_MEM = load)
//   PC_Src_Sel_E      in  branch/jump taken in Execute
//   load_use_s        out load in Execute feeds a source operand in Decode
//   branch_s          out taken branch/jump in Execute
module hazard_detector
  import pipeline_controller_pkg::*;
(
  input  logic [4:0] RS1_D,
  input  logic [4:0] RS2_D,
  input  logic [4:0] RD_E,
  input  logic [1:0] Result_Src_Sel_E,
  input  logic       PC_Src_Sel_E,
  output logic       load_use_s,
  output logic       branch_s
);

  // Hazard decode; x0 is never a real dependency.
  always_comb begin
    load_use_s = 1'b0;
    branch_s   = PC_Src_Sel_E;
    if ((Result_Src_Sel_E == RESULT_SRC_MEM) && (RD_E != 5'd0) &&
        ((RD_E == RS1_D) || (RD_E == RS2_D))) begin
      load_use_s = 1'b1;
    end else begin
      load_use_s = 1'b0;
    end
  end

endmodule

// File: rtl/pipeline_controller.sv
// pipeline_controller: stall/flush generation for a 5-stage pipeline with a
// variable-latency data memory.
// Ports:
//   CLK, RST                    clock and synchronous active-high reset
//   RS1_D, RS2_D, RD_E          register ids for load-use detection
//   Result_Src_Sel_E            result source in Execute
//   PC_Src_Sel_E                branch/jump taken in Execute
//   MEM_Req_M, MEM_Ready        memory access active / completing
//   Stall_F/D/E/M               hold PC, IF/ID, ID/EX, EX/MEM
//   Flush_D/E/W                 bubble into IF/ID, ID/EX, MEM/WB
//   MEM_Timeout                 one-cycle pulse after an abandoned wait
//   Stall_Count                 saturating count of memory-stalled cycles
module pipeline_controller
  import pipeline_controller_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic [4:0]  RS1_D,
  input  logic [4:0]  RS2_D,
  input  logic [4:0]  RD_E,
  input  logic [1:0]  Result_Src_Sel_E,
  input  logic        PC_Src_Sel_E,
  input  logic        MEM_Req_M,
  input  logic        MEM_Ready,
  output logic        Stall_F,
  output logic        Stall_D,
  output logic        Stall_E,
  output logic        Stall_M,
  output logic        Flush_D,
  output logic        Flush_E,
  output logic        Flush_W,
  output logic        MEM_Timeout,
  output logic [31:0] Stall_Count
);

  mem_ctrl_state_t       state_r;
  mem_ctrl_state_t       state_nxt_s;
  logic [WAIT_CNT_W-1:0] wait_cnt_r;
  logic [31:0]           stall_count_r;
  logic                  mem_timeout_r;
  logic                  timeout_s;
  logic                  mem_stall_s;
  logic                  load_use_s;
  logic                  branch_s;

  hazard_detector u_hazard_detector (
    .RS1_D            (RS1_D),
    .RS2_D            (RS2_D),
    .RD_E             (RD_E),
    .Result_Src_Sel_E (Result_Src_Sel_E),
    .PC_Src_Sel_E     (PC_Src_Sel_E),
    .load_use_s       (load_use_s),
    .branch_s         (branch_s)
  );

  // Memory FSM next state, stall condition and timeout detection.
  always_comb begin
    state_nxt_s = state_r;
    timeout_s   = 1'b0;
    mem_stall_s = 1'b0;
    case (state_r)
      IDLE: begin
        // A zero-wait access (ready with the request) never leaves IDLE.
        if (MEM_Req_M && !MEM_Ready) begin
          state_nxt_s = MEM_WAIT;
          mem_stall_s = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      MEM_WAIT: begin
        if (MEM_Ready) begin
          state_nxt_s = IDLE;
        end else if (wait_cnt_r == WAIT_CNT_LAST) begin
          // Give up: release the pipeline this cycle, pulse next cycle.
          state_nxt_s = IDLE;
          timeout_s   = 1'b1;
        end else begin
          state_nxt_s = MEM_WAIT;
          mem_stall_s = 1'b1;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Stall/flush priority: reset, memory stall, branch, load-use.
  // A branch frozen in Execute during a memory stall is still presented on
  // PC_Src_Sel_E, so its flush appears naturally on the release cycle.
  always_comb begin
    Stall_F = 1'b0;
    Stall_D = 1'b0;
    Stall_E = 1'b0;
    Stall_M = 1'b0;
    Flush_D = 1'b0;
    Flush_E = 1'b0;
    Flush_W = 1'b0;
    if (RST) begin
      Stall_F = 1'b0;
    end else if (mem_stall_s) begin
      Stall_F = 1'b1;
      Stall_D = 1'b1;
      Stall_E = 1'b1;
      Stall_M = 1'b1;
      Flush_W = 1'b1;
    end else if (branch_s) begin
      Flush_D = 1'b1;
      Flush_E = 1'b1;
    end else if (load_use_s) begin
      Stall_F = 1'b1;
      Stall_D = 1'b1;
      Flush_E = 1'b1;
    end else begin
      Stall_F = 1'b0;
    end
  end

  // State, wait counter, stall counter and timeout pulse registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r       <= IDLE;
      wait_cnt_r    <= WAIT_CNT_ZERO;
      stall_count_r <= 32'd0;
      mem_timeout_r <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      mem_timeout_r <= timeout_s;
      // Every entry to MEM_WAIT comes from IDLE, so clearing here clears on entry.
      if (state_r == IDLE) begin
        wait_cnt_r <= WAIT_CNT_ZERO;
      end else begin
        wait_cnt_r <= wait_cnt_r + WAIT_CNT_ONE;
      end
      if (mem_stall_s) begin
        stall_count_r <= sat_inc32(stall_count_r);
      end else begin
        stall_count_r <= stall_count_r;
      end
    end
  end

  assign MEM_Timeout = mem_timeout_r;
  assign Stall_Count = stall_count_r;

endmodule

// File: tb/tb_pipeline_controller.sv
// Scoreboard bench for pipeline_controller: the driver applies one directed
// vector per cycle and queues the hand-computed outputs; the monitor pops and
// compares the whole output tuple on the falling edge.
module tb_pipeline_controller;
  import pipeline_controller_pkg::*;

  logic        CLK;
  logic        RST;
  logic [4:0]  RS1_D;
  logic [4:0]  RS2_D;
  logic [4:0]  RD_E;
  logic [1:0]  Result_Src_Sel_E;
  logic        PC_Src_Sel_E;
  logic        MEM_Req_M;
  logic        MEM_Ready;
  logic        Stall_F;
  logic        Stall_D;
  logic        Stall_E;
  logic        Stall_M;
  logic        Flush_D;
  logic        Flush_E;
  logic        Flush_W;
  logic        MEM_Timeout;
  logic [31:0] Stall_Count;

  typedef struct {
    string       name;
    logic [3:0]  stall;   // {F,D,E,M}
    logic [2:0]  flush;   // {D,E,W}
    logic        tmo;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;

  pipeline_controller dut (
    .CLK              (CLK),
    .RST              (RST),
    .RS1_D            (RS1_D),
    .RS2_D            (RS2_D),
    .RD_E             (RD_E),
    .Result_Src_Sel_E (Result_Src_Sel_E),
    .PC_Src_Sel_E     (PC_Src_Sel_E),
    .MEM_Req_M        (MEM_Req_M),
    .MEM_Ready        (MEM_Ready),
    .Stall_F          (Stall_F),
    .Stall_D          (Stall_D),
    .Stall_E          (Stall_E),
    .Stall_M          (Stall_M),
    .Flush_D          (Flush_D),
    .Flush_E          (Flush_E),
    .Flush_W          (Flush_W),
    .MEM_Timeout      (MEM_Timeout),
    .Stall_Count      (Stall_Count)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Apply one cycle of stimulus and queue its expected outputs.
  task automatic step(input string name, input logic rst,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                      input logic [1:0] rsrc, input logic pcs, input logic req, input logic rdy,
                      input logic [3:0] e_stall, input logic [2:0] e_flush,
                      input logic e_tmo, input logic [31:0] e_cnt);
    exp_t e;
    @(posedge CLK);
    #1;
    RST              = rst;
    RS1_D            = rs1;
    RS2_D            = rs2;
    RD_E             = rd;
    Result_Src_Sel_E = rsrc;
    PC_Src_Sel_E     = pcs;
    MEM_Req_M        = req;
    MEM_Ready        = rdy;
    e.name  = name;
    e.stall = e_stall;
    e.flush = e_flush;
    e.tmo   = e_tmo;
    e.cnt   = e_cnt;
    sb_q.push_back(e);
  endtask

  // Monitor: compare every queued expectation against the settled outputs.
  always @(negedge CLK) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      n_checks++;
      if (({Stall_F, Stall_D, Stall_E, Stall_M} === mon_e.stall) &&
          ({Flush_D, Flush_E, Flush_W} === mon_e.flush) &&
          (MEM_Timeout === mon_e.tmo) && (Stall_Count === mon_e.cnt)) begin
        n_pass++;
      end else begin
        $display("FAIL %s: got stall=%b flush=%b tmo=%b cnt=%0d, expected stall=%b flush=%b tmo=%b cnt=%0d",
                 mon_e.name, {Stall_F, Stall_D, Stall_E, Stall_M}, {Flush_D, Flush_E, Flush_W},
                 MEM_Timeout, Stall_Count, mon_e.stall, mon_e.flush, mon_e.tmo, mon_e.cnt);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    RST = 1'b1; RS1_D = 5'd0; RS2_D = 5'd0; RD_E = 5'd0;
    Result_Src_Sel_E = 2'b00; PC_Src_Sel_E = 1'b0; MEM_Req_M = 1'b0; MEM_Ready = 1'b0;
    repeat (2) @(posedge CLK);

    // Reset gates every hazard source.
    step("reset_gate", 1'b1, 5'd5, 5'd0, 5'd5, 2'b01, 1'b1, 1'b1, 1'b0, 4'b0000, 3'b000, 1'b0, 32'd0);
    step("idle",       1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0, 4'b0000, 3'b000, 1'b0, 32'd0);
    // Load-use, branch and non-hazard patterns.
    step("load_use_rs1", 1'b0, 5'd5, 5'd0, 5'd5, 2'b01, 1'b0, 1'b0, 1'b0, 4'b1100, 3'b010, 1'b0, 32'd0);
    step("load_use_rs2", 1'b0, 5'd3, 5'd5, 5'd5, 2'b01, 1'b0, 1'b0, 1'b0, 4'b1100, 3'b010, 1'b0, 32'd0);
    step("rd_zero",      1'b0, 5'd0, 5'd0, 5'd0, 2'b01, 1'b0, 1'b0, 1'b0, 4'b0000, 3'b000, 1'b0, 32'd0);
    step("alu_no_hz",    1'b0, 5'd5, 5'd0, 5'd5, 2'b00, 1'b0, 1'b0, 1'b0, 4'b0000, 3'b000, 1'b0, 32'd0);
    step("branch_prio",  1'b0, 5'd5, 5'd0, 5'd5, 2'b01, 1'b1, 1'b0, 1'b0, 4'b0000, 3'b110, 1'b0, 32'd0);
    // Zero-wait access, then confirm still IDLE (MEM_WAIT would stall here).
    step("zero_wait",    1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b1, 1'b1, 4'b0000, 3'b000, 1'b0, 32'd0);
    step("zw_idle",      1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0, 4'b0000, 3'b000, 1'b0, 32'd0);
    // Three-cycle miss; load-use present but suppressed.
    step("miss_c1",      1'b0, 5'd5, 5'd0, 5'd5, 2'b01, 1'b0, 1'b1, 1'b0, 4'b1111, 3'b001, 1'b0, 32'd0);
    step("miss_c2",      1'b0, 5'd5, 5'd0, 5'd5, 2'b01, 1'b0, 1'b1, 1'b0, 4'b1111, 3'b001, 1'b0, 32'd1);
    step("miss_c3",      1'b0, 5'd5, 5'd0, 5'd5, 2'b01, 1'b0, 1'b1, 1'b0, 4'b1111, 3'b001, 1'b0, 32'd2);
    step("miss_release", 1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b1, 1'b1, 4'b0000, 3'b000, 1'b0, 32'd3);
    step("miss_idle",    1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0, 4'b0000, 3'b000, 1'b0, 32'd3);
    // Branch frozen in Execute through a two-cycle miss.
    step("frz_c1",       1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b1, 1'b1, 1'b0, 4'b1111, 3'b001, 1'b0, 32'd3);
    step("frz_c2",       1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b1, 1'b1, 1'b0, 4'b1111, 3'b001, 1'b0, 32'd4);
    step("frz_release",  1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b1, 1'b1, 1'b1, 4'b0000, 3'b110, 1'b0, 32'd5);
    step("frz_after",    1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0, 4'b0000, 3'b000, 1'b0, 32'd5);
    // Reset on the second MEM_WAIT cycle.
    step("rst_c1",       1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b1, 1'b0, 4'b1111, 3'b001, 1'b0, 32'd5);
    step("rst_c2",       1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b1, 1'b0, 4'b1111, 3'b001, 1'b0, 32'd6);
    step("rst_pulse",    1'b1, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b1, 1'b0, 4'b0000, 3'b000, 1'b0, 32'd7);
    step("rst_after",    1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0, 4'b0000, 3'b000, 1'b0, 32'd0);
    step("rst_after2",   1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0, 4'b0000, 3'b000, 1'b0, 32'd0);
    // Timeout: request held 300 cycles with no ready.
    for (int t = 1; t <= 300; t++) begin
      if (t <= 256) begin
        step("tmo_wait", 1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b1, 1'b0,
             4'b1111, 3'b001, 1'b0, 32'(t - 1));
      end else if (t == 257) begin
        step("tmo_abandon", 1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b1, 1'b0,
             4'b0000, 3'b000, 1'b0, 32'd256);
      end else begin
        step("tmo_rewait", 1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b1, 1'b0,
             4'b1111, 3'b001, (t == 258) ? 1'b1 : 1'b0, 32'(256 + t - 258));
      end
    end
    step("tmo_release",  1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b1, 4'b0000, 3'b000, 1'b0, 32'd299);
    step("tmo_idle",     1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0, 4'b0000, 3'b000, 1'b0, 32'd299);

    @(posedge CLK);
    @(negedge CLK);
    #1;
    if (sb_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", sb_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
